// File: rtl/regfile_debug_ctrl.sv
// regfile_debug_ctrl
// -----------------------------------------------------------------------------
// Debug-side sequencer for the register file's debug port. It takes one
// register read or write command at a time from the debug transport and asks
// the core to halt when it is not already halted. It then performs the access
// through the register file's debug port and returns data or an error on the
// response channel. After a clean access it can optionally pulse a resume.
//
// Ports
//   clk_i              system clock, everything on the rising edge
//   rst_ni             asynchronous active-low reset
//   state_i            processor state, compared against STATE_HALTED
//   halt_req_o         level halt request, held while waiting for the halt
//   resume_req_o       one-cycle resume pulse
//   cmd_valid_i/cmd_ready_o       command handshake
//   cmd_write_i        1 = write, 0 = read
//   cmd_regnum_i       target register number
//   cmd_wdata_i        write data
//   cmd_resume_i       resume the core after a successful access
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_rdata_o        read data, or echoed write data; 0 on error
//   rsp_err_o          bad regnum, halt timeout, or halt lost during access
//   dbg_reg_rregnum_o  register file debug read index
//   dbg_reg_wregnum_o  register file debug write index
//   dbg_reg_rdata_i    register file debug read data (combinational)
//   dbg_reg_wdata_o    register file debug write data
//   dbg_reg_we_o       register file debug write enable
// -----------------------------------------------------------------------------
module regfile_debug_ctrl #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned HALT_TIMEOUT = 255,
  parameter int unsigned TMO_W        = 8,
  parameter logic [2:0]  STATE_HALTED = 3'd2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  state_i,
  output logic        halt_req_o,
  output logic        resume_req_o,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [5:0]  cmd_regnum_i,
  input  logic [15:0] cmd_wdata_i,
  input  logic        cmd_resume_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [5:0]  dbg_reg_rregnum_o,
  output logic [5:0]  dbg_reg_wregnum_o,
  input  logic [15:0] dbg_reg_rdata_i,
  output logic [15:0] dbg_reg_wdata_o,
  output logic        dbg_reg_we_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    ACCESS,
    RESPOND,
    RESUME
  } fsm_e;

  // Counter value on the last permitted wait cycle. When HALT_TIMEOUT is 0,
  // this value wraps, but tmo_en masks it out.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);
  localparam logic             TMO_EN   = (HALT_TIMEOUT != 0);

  fsm_e             fsm_q;
  logic [TMO_W-1:0] cnt_q;
  logic             write_q;
  logic             resume_q;
  logic [5:0]       regnum_q;
  logic [15:0]      wdata_q;
  logic             cmd_ready_q;
  logic             halt_req_q;
  logic             resume_req_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [15:0]      rsp_rdata_q;

  logic             halted;
  logic             accept;
  logic             regnum_bad;
  logic             tmo_hit;
  logic             acc_err_d;
  logic [15:0]      acc_rdata_d;

  always_comb begin
    halted     = (state_i == STATE_HALTED);
    accept     = cmd_valid_i & cmd_ready_q;
    // All six bits take part, so indices 16..63 are rejected and not aliased.
    regnum_bad = (32'(cmd_regnum_i) >= NUM_REGS);
    tmo_hit    = TMO_EN && (cnt_q == TMO_LAST);
    // The access result is decided by the halt status in the ACCESS cycle.
    // If the halt is lost in that cycle, the access turns into an error.
    acc_err_d   = ~halted;
    acc_rdata_d = 16'h0000;
    if (halted) begin
      acc_rdata_d = write_q ? wdata_q : dbg_reg_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q        <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      resume_q     <= 1'b0;
      regnum_q     <= 6'd0;
      wdata_q      <= 16'h0000;
      cmd_ready_q  <= 1'b0;
      halt_req_q   <= 1'b0;
      resume_req_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 16'h0000;
    end else begin
      resume_req_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          // After reset, ready rises one edge later. It stays high until accept.
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write_i;
            resume_q    <= cmd_resume_i;
            regnum_q    <= cmd_regnum_i;
            wdata_q     <= cmd_wdata_i;
            cnt_q       <= '0;
            if (regnum_bad) begin
              fsm_q       <= RESPOND;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 16'h0000;
            end else if (halted) begin
              fsm_q <= ACCESS;
            end else begin
              fsm_q      <= WAIT_HALT;
              halt_req_q <= 1'b1;
            end
          end
        end

        WAIT_HALT: begin
          cnt_q <= cnt_q + TMO_W'(1);
          // If the halt arrives on the last wait cycle, it takes priority over the timeout.
          if (halted) begin
            halt_req_q <= 1'b0;
            fsm_q      <= ACCESS;
          end else if (tmo_hit) begin
            halt_req_q  <= 1'b0;
            fsm_q       <= RESPOND;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 16'h0000;
          end
        end

        ACCESS: begin
          fsm_q       <= RESPOND;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= acc_err_d;
          rsp_rdata_q <= acc_rdata_d;
        end

        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            // A command that ended in error never resumes the core.
            if (resume_q && !rsp_err_q) begin
              fsm_q        <= RESUME;
              resume_req_q <= 1'b1;
            end else begin
              fsm_q       <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end

        RESUME: begin
          fsm_q       <= IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o       = cmd_ready_q;
  assign halt_req_o        = halt_req_q;
  assign resume_req_o      = resume_req_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_err_o         = rsp_err_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  // The indices follow the captured command in every state, so the read
  // index has settled before ACCESS.
  assign dbg_reg_rregnum_o = regnum_q;
  assign dbg_reg_wregnum_o = regnum_q;
  assign dbg_reg_wdata_o   = wdata_q;
  // The write enable is combinational so that a halt lost in the access cycle
  // blocks the write in that same cycle.
  assign dbg_reg_we_o      = (fsm_q == ACCESS) & write_q & halted;

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// tb_regfile_debug_ctrl
// -----------------------------------------------------------------------------
// The bench plans the whole run in advance as per-cycle tables. Each command is
// turned into a timeline using plain arithmetic: the accept cycle, the wait
// cycles, the access cycle, the response window and the resume pulse. Those
// tables give both the inputs to drive and the outputs to expect.
// A small register file array answers the DUT's debug port.
// -----------------------------------------------------------------------------
module tb_regfile_debug_ctrl;

  localparam int         N      = 4096;
  localparam int         TMO    = 4;
  localparam logic [2:0] HALTED = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  state;
  logic        halt_req, resume_req;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_resume;
  logic [5:0]  cmd_regnum;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [5:0]  dbg_rregnum, dbg_wregnum;
  logic [15:0] dbg_rdata, dbg_wdata;
  logic        dbg_we;

  always #5 clk = ~clk;

  regfile_debug_ctrl #(
    .NUM_REGS(16), .HALT_TIMEOUT(TMO), .TMO_W(8), .STATE_HALTED(HALTED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .state_i(state),
    .halt_req_o(halt_req), .resume_req_o(resume_req),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_regnum_i(cmd_regnum), .cmd_wdata_i(cmd_wdata), .cmd_resume_i(cmd_resume),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .dbg_reg_rregnum_o(dbg_rregnum),
    .dbg_reg_wregnum_o(dbg_wregnum), .dbg_reg_rdata_i(dbg_rdata),
    .dbg_reg_wdata_o(dbg_wdata), .dbg_reg_we_o(dbg_we)
  );

  // Register file that answers the debug port.
  logic [15:0] rf [16];
  assign dbg_rdata = rf[dbg_rregnum[3:0]];
  always @(posedge clk) if (dbg_we) rf[dbg_wregnum[3:0]] <= dbg_wdata;

  // Per-cycle stimulus tables.
  logic        in_valid [N];
  logic        in_write [N];
  logic [5:0]  in_regnum[N];
  logic [15:0] in_wdata [N];
  logic        in_resume[N];
  logic [2:0]  st       [N];
  logic        in_ready [N];
  // Per-cycle expected outputs.
  logic        e_ready [N];
  logic        e_halt  [N];
  logic        e_resume[N];
  logic        e_rv    [N];
  logic [15:0] e_rdata [N];
  logic        e_err   [N];
  logic        e_we    [N];
  logic [5:0]  e_regnum[N];
  logic [15:0] e_wdata [N];

  logic [15:0] pregs [16];   // register contents the model expects
  int          t;            // first cycle the block is free for the next command
  logic [5:0]  cur_rn;
  logic [15:0] cur_wd;
  int          plan_len;

  int tests = 0;
  int fails = 0;
  bit active = 1'b0;
  int cyc_cur = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  function automatic logic [2:0] run_val();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 2) v++;
    return 3'(v);
  endfunction

  // mode: 0 = core already halted, 1 = halts in wait cycle d, 2 = never halts.
  // drop: the halt is lost in the access cycle. k: response back-pressure cycles.
  task automatic plan_txn(input int gap, input bit wr, input int rn, input logic [15:0] wd,
                          input bit rs, input int mode, input int d, input bit drop, input int k);
    int a, s, x, h, nt, c;
    bit err, timed_out;
    logic [15:0] rd;
    for (int i = t; i < t + gap; i++) begin
      e_ready[i] = 1'b1;
      in_valid[i] = 1'b0;
    end
    a = t + gap;
    e_ready[a] = 1'b1;
    in_valid[a] = 1'b1;
    in_write[a] = wr;
    in_regnum[a] = 6'(rn);
    in_wdata[a] = wd;
    in_resume[a] = rs;
    for (int i = t; i <= a; i++) begin
      e_regnum[i] = cur_rn;
      e_wdata[i] = cur_wd;
    end
    err = 1'b0;
    rd = 16'h0000;
    timed_out = 1'b0;
    x = 0;
    s = 0;
    if (rn >= 16) begin
      err = 1'b1;
      s = a + 1;
    end else begin
      if (mode == 0) begin
        st[a] = HALTED;
        x = a + 1;
      end else begin
        st[a] = run_val();
        for (int j = 0; j < 1000; j++) begin
          c = a + 1 + j;
          e_halt[c] = 1'b1;
          if (mode == 1 && j >= d) begin
            st[c] = HALTED;
            x = c + 1;
            break;
          end
          st[c] = run_val();
          if (j == TMO - 1) begin
            timed_out = 1'b1;
            err = 1'b1;
            s = c + 1;
            break;
          end
        end
      end
      if (!timed_out) begin
        st[x] = drop ? run_val() : HALTED;
        err = drop;
        e_we[x] = wr & !drop;
        if (!drop) rd = wr ? wd : pregs[rn];
        if (wr && !drop) pregs[rn] = wd;
        s = x + 1;
      end
    end
    h = s + k;
    for (int i = s; i <= h; i++) begin
      e_rv[i] = 1'b1;
      e_rdata[i] = rd;
      e_err[i] = err;
      in_ready[i] = (i == h);
    end
    if (rs && !err) begin
      e_resume[h + 1] = 1'b1;
      nt = h + 2;
    end else begin
      nt = h + 1;
    end
    cur_rn = 6'(rn);
    cur_wd = wd;
    for (int i = a + 1; i < nt; i++) begin
      e_regnum[i] = cur_rn;
      e_wdata[i] = cur_wd;
    end
    t = nt;
  endtask

  // The comparison process checks every planned cycle against the tables.
  // It also pins the directed commands with cycle numbers worked out by hand.
  always @(negedge clk) begin
    int c;
    if (active) begin
      c = cyc_cur;
      chk("cmd_ready", c, 32'(cmd_ready), 32'(e_ready[c]));
      chk("halt_req", c, 32'(halt_req), 32'(e_halt[c]));
      chk("resume_req", c, 32'(resume_req), 32'(e_resume[c]));
      chk("rsp_valid", c, 32'(rsp_valid), 32'(e_rv[c]));
      chk("dbg_we", c, 32'(dbg_we), 32'(e_we[c]));
      chk("rregnum", c, 32'(dbg_rregnum), 32'(e_regnum[c]));
      chk("wregnum", c, 32'(dbg_wregnum), 32'(e_regnum[c]));
      chk("dbg_wdata", c, 32'(dbg_wdata), 32'(e_wdata[c]));
      if (e_rv[c]) begin
        chk("rsp_rdata", c, 32'(rsp_rdata), 32'(e_rdata[c]));
        chk("rsp_err", c, 32'(rsp_err), 32'(e_err[c]));
      end
      case (c)
        1:  chk("lit_rv_c1", c, 32'(rsp_valid), 32'd0);
        2:  begin
              chk("lit_rv_c2", c, 32'(rsp_valid), 32'd1);
              chk("lit_rd_c2", c, 32'(rsp_rdata), 32'h1234);
              chk("lit_err_c2", c, 32'(rsp_err), 32'd0);
            end
        7:  chk("lit_halt_c7", c, 32'(halt_req), 32'd1);
        8:  begin
              chk("lit_we_c8", c, 32'(dbg_we), 32'd1);
              chk("lit_wreg_c8", c, 32'(dbg_wregnum), 32'd7);
              chk("lit_wdata_c8", c, 32'(dbg_wdata), 32'hBEEF);
              chk("lit_halt_c8", c, 32'(halt_req), 32'd0);
            end
        9:  chk("lit_rd_c9", c, 32'(rsp_rdata), 32'hBEEF);
        10: chk("lit_resume_c10", c, 32'(resume_req), 32'd1);
        12: begin
              chk("lit_rv_c12", c, 32'(rsp_valid), 32'd1);
              chk("lit_err_c12", c, 32'(rsp_err), 32'd1);
              chk("lit_rd_c12", c, 32'(rsp_rdata), 32'd0);
            end
        17: chk("lit_halt_c17", c, 32'(halt_req), 32'd1);
        18: begin
              chk("lit_err_c18", c, 32'(rsp_err), 32'd1);
              chk("lit_halt_c18", c, 32'(halt_req), 32'd0);
            end
        19: begin
              chk("lit_resume_c19", c, 32'(resume_req), 32'd0);
              chk("lit_ready_c19", c, 32'(cmd_ready), 32'd1);
            end
        30: begin
              chk("lit_rv_c30", c, 32'(rsp_valid), 32'd1);
              chk("lit_ready_c30", c, 32'(cmd_ready), 32'd0);
              chk("lit_rd_c30", c, 32'(rsp_rdata), 32'h1234);
            end
        default: ;
      endcase
    end
  end

  initial begin
    logic [15:0] old_r2;
    int rn;
    // The register file and the model's copy start with the same contents.
    for (int i = 0; i < 16; i++) begin
      pregs[i] = 16'($urandom);
      rf[i] = pregs[i];
    end
    pregs[5] = 16'h1234;
    rf[5] = 16'h1234;
    // Fill every cycle with random values. The planner then sets the cycles that matter.
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'($urandom);
      in_write[i] = 1'($urandom);
      in_regnum[i] = 6'($urandom);
      in_wdata[i] = 16'($urandom);
      in_resume[i] = 1'($urandom);
      st[i] = 3'($urandom);
      in_ready[i] = 1'($urandom);
      e_ready[i] = 1'b0; e_halt[i] = 1'b0; e_resume[i] = 1'b0; e_rv[i] = 1'b0;
      e_rdata[i] = 16'h0; e_err[i] = 1'b0; e_we[i] = 1'b0;
      e_regnum[i] = 6'd0; e_wdata[i] = 16'h0;
    end
    t = 0;
    cur_rn = 6'd0;
    cur_wd = 16'h0;
    // Directed commands. Their cycle numbers are pinned in the compare process.
    plan_txn(0, 1'b0, 5, 16'h0000, 1'b0, 0, 0, 1'b0, 0);   // halted read r5
    plan_txn(0, 1'b1, 7, 16'hBEEF, 1'b1, 1, 3, 1'b0, 0);   // halt then write r7 + resume
    plan_txn(0, 1'b0, 20, 16'h5555, 1'b0, 0, 0, 1'b0, 0);  // out-of-range regnum
    plan_txn(0, 1'b1, 3, 16'hCAFE, 1'b1, 2, 0, 1'b0, 0);   // halt timeout
    plan_txn(0, 1'b0, 5, 16'h0000, 1'b0, 0, 0, 1'b0, 10);  // long back-pressure
    // Random commands.
    while (t < N - 64) begin
      rn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
      plan_txn(int'($urandom_range(0, 2)), 1'($urandom), rn, 16'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end
    plan_len = t;

    rst_n = 1'b0;
    state = 3'd0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_regnum = 6'd0;
    cmd_wdata = 16'h0; cmd_resume = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < plan_len; c++) begin
      @(posedge clk);
      #1;
      cmd_valid = in_valid[c]; cmd_write = in_write[c]; cmd_regnum = in_regnum[c];
      cmd_wdata = in_wdata[c]; cmd_resume = in_resume[c]; state = st[c];
      rsp_ready = in_ready[c];
      cyc_cur = c;
      active = 1'b1;
    end
    @(posedge clk);
    #1;
    active = 1'b0;

    // Reset while waiting for a halt: outputs clear at once, there is no write,
    // and the block comes back idle.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_regnum = 6'd2; cmd_wdata = 16'hFFFF;
    cmd_resume = 1'b1; state = run_val(); rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rst_pre_halt1", plan_len + 1, 32'(halt_req), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_pre_halt2", plan_len + 2, 32'(halt_req), 32'd1);
    old_r2 = rf[2];
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_halt_req", -1, 32'(halt_req), 32'd0);
    chk("rst_cmd_ready", -1, 32'(cmd_ready), 32'd0);
    chk("rst_resume", -1, 32'(resume_req), 32'd0);
    chk("rst_rsp_valid", -1, 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", -1, 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", -1, 32'(rsp_err), 32'd0);
    chk("rst_regnum", -1, 32'(dbg_rregnum), 32'd0);
    chk("rst_wdata", -1, 32'(dbg_wdata), 32'd0);
    chk("rst_we", -1, 32'(dbg_we), 32'd0);
    state = HALTED;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", -1, 32'(cmd_ready), 32'd1);
    chk("post_rst_rv", -1, 32'(rsp_valid), 32'd0);
    chk("post_rst_halt", -1, 32'(halt_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle_rv", i, 32'(rsp_valid), 32'd0);
      chk("post_rst_idle_resume", i, 32'(resume_req), 32'd0);
      chk("post_rst_idle_ready", i, 32'(cmd_ready), 32'd1);
    end
    chk("rst_no_write_r2", -1, 32'(rf[2]), 32'(old_r2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_debug_ctrl.md
Name: regfile_debug_ctrl

Overview:
Debug-side sequencer for the register file's debug port. It accepts single register read/write commands from the debug transport over a valid/ready handshake. It requests a processor halt if needed, then performs the access through the register file's debug read/write port. It returns the read data or an error over a valid/ready response channel, and optionally resumes the core afterwards.

Parameters:
NUM_REGS, 16, number of implemented registers; any regnum >= NUM_REGS is rejected with an error.
HALT_TIMEOUT, 255, cycles to wait for halt before failing; 0 disables the timeout (wait forever).
TMO_W, 8, width of the halt-wait counter; must be able to hold HALT_TIMEOUT.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset (asserts regardless of clk; deassertion sampled on clk)
state  in  3  processor state; compared against `STATE_HALTED from aap.h
halt_req  out  1  level request to halt the core
resume_req  out  1  single-cycle resume pulse
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_regnum  in  6  target register
cmd_wdata  in  16  write data
cmd_resume  in  1  issue resume after a successful access
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  16  read data (read) / echoed write data (write); 0 on error
rsp_err  out  1  bad regnum, halt timeout, or halt lost during access
dbg_reg_rregnum  out  6  register file debug read index
dbg_reg_wregnum  out  6  register file debug write index
dbg_reg_rdata  in  16  register file debug read data (combinational from index)
dbg_reg_wdata  out  16  register file debug write data
dbg_reg_we  out  1  register file debug write enable

Behaviour:
- FSM states: IDLE, WAIT_HALT, ACCESS, RESPOND, RESUME. Reset -> IDLE.
- Reset values: all outputs 0, counter 0, capture registers 0. Reset mid-operation aborts with no write, drops halt_req, and emits no response or resume.
- IDLE: cmd_ready=1. It is the only state with cmd_ready=1, so at most one command is in flight.
  - On cmd_valid&cmd_ready, capture write, regnum, wdata and resume.
  - If regnum >= NUM_REGS -> RESPOND with err=1 and rdata=0; no halt, no access.
  - Else if state==`STATE_HALTED -> ACCESS.
  - Else -> WAIT_HALT.
- WAIT_HALT: halt_req=1 (registered, rises the cycle after accept) and the counter increments each cycle.
  - If state==`STATE_HALTED -> ACCESS, and halt_req drops.
  - Else if HALT_TIMEOUT!=0 and counter==HALT_TIMEOUT-1 -> RESPOND with err=1, and halt_req drops.
  - The counter clears on entry.
- ACCESS (exactly 1 cycle):
  - dbg_reg_rregnum and dbg_reg_wregnum are driven from the captured regnum in every state, so the read index is stable before ACCESS.
  - dbg_reg_wdata = captured wdata.
  - dbg_reg_we = (FSM==ACCESS) & captured write & (state==`STATE_HALTED), combinational.
  - Read: sample dbg_reg_rdata into rsp_rdata at the end of the cycle. Write: rsp_rdata = wdata.
  - If state!=`STATE_HALTED in this cycle: err=1, rdata=0, no write.
  - Always -> RESPOND.
- RESPOND: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake, if captured resume & !err -> RESUME, else -> IDLE.
  - rsp_valid drops the cycle after the handshake.
- RESUME: resume_req=1 for exactly one cycle, then -> IDLE.
- Latency with the core already halted: accept on edge N, ACCESS during cycle N+1, rsp_valid=1 from N+2. A back-to-back command can be accepted 1 cycle after the response handshake (2 cycles if resuming).
- Regnum range: 6-bit ports pass the full value. The range check uses all 6 bits, so 16..63 gives an error when NUM_REGS=16.
- halt_req and resume_req are never asserted together. The block never resumes a core after an errored command.

Test Plan:
- Core halted; read r5 holding 0x1234 -> rsp_valid 2 cycles after accept, rdata=0x1234, err=0, dbg_reg_we never high, no halt_req.
- Core running; state goes HALTED 3 cycles after halt_req; write r7=0xBEEF with cmd_resume=1 -> one dbg_reg_we pulse with wregnum=7 and wdata=0xBEEF; response rdata=0xBEEF, err=0; then one resume_req pulse.
- cmd_regnum=20 -> immediate response with err=1 and rdata=0; no halt_req, no dbg_reg_we.
- HALT_TIMEOUT=4; core never halts -> halt_req high for 4 cycles, then response err=1; no write, no resume even with cmd_resume=1.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid, rdata and err stay stable, and cmd_ready stays 0 throughout.
- Assert rst low during WAIT_HALT -> all outputs 0 immediately (asynchronously); after release, the block is in IDLE with cmd_ready=1 and no stale response.
